stopwatch_controller: RTL and testbench

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

---
 rtl/stopwatch_pkg.sv | 35 +++
 rtl/mod_m_counter.sv | 51 +++++
 rtl/stopwatch_controller.sv | 152 +++++++++++++++
 tb/tb_stopwatch_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller slice.
//
// Contents:
//   DIV_DEFAULT - clk_i cycles per 0.1 s count tick for a 100 MHz system clock
//   sw_state_e  - controller FSM state encoding (visible on state_o)
//   sw_req_e    - the single request chosen from the four request pulses
//   is_counting - true for the states in which the prescaler advances
package stopwatch_pkg;

  localparam int unsigned DIV_DEFAULT = 10_000_000;

  // The encoding is exported on state_o, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  // At most one request is acted on per cycle. Clear outranks stop,
  // stop outranks start, and start outranks lap.
  typedef enum logic [2:0] {
    REQ_NONE  = 3'd0,
    REQ_CLEAR = 3'd1,
    REQ_STOP  = 3'd2,
    REQ_START = 3'd3,
    REQ_LAP   = 3'd4
  } sw_req_e;

  // The stopwatch is timing in both RUN and LAP. LAP only freezes the display.
  function automatic logic is_counting(input sw_state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Modulo-M prescaler: counts 0..M-1 while enabled and wraps back to 0.
//
// Ports:
//   clk_i      - system clock
//   rst_i      - synchronous active-high reset, zeroes the count
//   en_i       - advance the count this cycle
//   clr_i      - synchronous clear, zeroes the count (overrides en_i)
//   max_tick_o - high while the count equals M-1 (combinational from the flop)
module mod_m_counter #(
  parameter int unsigned M = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic max_tick_o
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] LAST = W'(M - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise advance and wrap at M-1.
  // With en_i low the value is held, which is what keeps the partial
  // period intact while the stopwatch is paused.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign max_tick_o = (count_q == LAST);

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM. It paces a BCD counter datapath with a 0.1 s
// count-enable, handles start/stop/clear/lap requests, and selects what the
// 7-segment display shows.
//
// Ports:
//   clk_i       - system clock
//   rst_i       - synchronous active-high reset
//   start_i     - one-cycle start/resume request
//   stop_i      - one-cycle pause request
//   clear_i     - one-cycle clear request
//   lap_i       - one-cycle lap freeze/release toggle
//   count_bcd_i - live 4-digit BCD count from the datapath
//   max_i       - datapath count is 9999
//   tick_o      - one-cycle count-enable to the datapath
//   clr_o       - one-cycle synchronous clear to the datapath (registered)
//   disp_bcd_o  - BCD value for the display driver
//   state_o     - current FSM state encoding
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        clear_i,
  input  logic        lap_i,
  input  logic [15:0] count_bcd_i,
  input  logic        max_i,
  output logic        tick_o,
  output logic        clr_o,
  output logic [15:0] disp_bcd_o,
  output logic [1:0]  state_o
);

  sw_state_e   state_q;
  sw_state_e   state_d;
  logic        clr_q;
  logic        clr_d;
  logic [15:0] lap_q;
  logic [15:0] lap_d;

  sw_req_e     req;
  logic        counting;
  logic        period_end;
  logic        saturate;

  // Reduce the four request pulses to the single winning request.
  always_comb begin
    req = REQ_NONE;
    if (clear_i) begin
      req = REQ_CLEAR;
    end else if (stop_i) begin
      req = REQ_STOP;
    end else if (start_i) begin
      req = REQ_START;
    end else if (lap_i) begin
      req = REQ_LAP;
    end
  end

  assign counting = is_counting(state_q);

  // The prescaler runs only while timing and is zeroed by an accepted
  // clear. It counts during the cycle in which a stop is accepted, so a
  // resume continues from the following fraction of the period.
  mod_m_counter #(
    .M(DIV)
  ) u_prescaler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (counting),
    .clr_i     (req == REQ_CLEAR),
    .max_tick_o(period_end)
  );

  // A period that ends with the datapath already at 9999 must not advance
  // it; the watch stops there instead of rolling over to 0000.
  assign saturate = period_end && counting && max_i;

  // State register. Reset also discards all requests of that cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      clr_q   <= 1'b0;
      lap_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      lap_q   <= lap_d;
    end
  end

  // Next-state logic. Clear always returns to IDLE; saturation at 9999
  // forces PAUSE ahead of any stop/start/lap. Requests that have no
  // meaning in the current state leave it unchanged.
  always_comb begin
    state_d = state_q;
    if (req == REQ_CLEAR) begin
      state_d = ST_IDLE;
    end else if (saturate) begin
      state_d = ST_PAUSE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req == REQ_START) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (req == REQ_STOP) begin
            state_d = ST_PAUSE;
          end else if (req == REQ_LAP) begin
            state_d = ST_LAP;
          end
        end
        ST_PAUSE: begin
          if (req == REQ_START) state_d = ST_RUN;
        end
        ST_LAP: begin
          if (req == REQ_STOP) begin
            state_d = ST_PAUSE;
          end else if (req == REQ_LAP) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered side effects of the transition: the datapath clear pulse,
  // and the lap snapshot, taken only on entry to LAP from RUN so the
  // frozen value never moves while LAP is held.
  always_comb begin
    clr_d = (req == REQ_CLEAR);
    lap_d = lap_q;
    if ((state_q == ST_RUN) && (state_d == ST_LAP)) begin
      lap_d = count_bcd_i;
    end
  end

  // Output logic. tick_o is combinational so the datapath advances in the
  // same cycle the prescaler wraps; reset blanks it so an abandoned
  // period never produces a stray count.
  always_comb begin
    tick_o     = period_end && counting && !max_i && !rst_i;
    clr_o      = clr_q;
    state_o    = state_q;
    disp_bcd_o = (state_q == ST_LAP) ? lap_q : count_bcd_i;
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller with DIV=4. Each table row holds
// the inputs for one clock cycle and the outputs expected during that same
// cycle; rows are applied back to back so row index equals cycle number.
module tb_stopwatch_controller;

  localparam int unsigned DIV = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stop_i;
  logic        clear_i;
  logic        lap_i;
  logic [15:0] count_bcd_i;
  logic        max_i;
  logic        tick_o;
  logic        clr_o;
  logic [15:0] disp_bcd_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        start;
    logic        stop;
    logic        clear;
    logic        lap;
    logic        max;
    logic [15:0] cnt;
    logic        tick;
    logic        clr;
    logic [1:0]  st;
    logic [15:0] disp;
  } vec_t;

  vec_t vecs[$];

  stopwatch_controller #(
    .DIV(DIV)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .clear_i    (clear_i),
    .lap_i      (lap_i),
    .count_bcd_i(count_bcd_i),
    .max_i      (max_i),
    .tick_o     (tick_o),
    .clr_o      (clr_o),
    .disp_bcd_o (disp_bcd_o),
    .state_o    (state_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void add_vec(input logic rst, input logic start, input logic stop,
                                  input logic clear, input logic lap, input logic max,
                                  input logic [15:0] cnt, input logic tick, input logic clr,
                                  input logic [1:0] st, input logic [15:0] disp);
    vec_t v;
    v.rst = rst; v.start = start; v.stop = stop; v.clear = clear; v.lap = lap;
    v.max = max; v.cnt = cnt; v.tick = tick; v.clr = clr; v.st = st; v.disp = disp;
    vecs.push_back(v);
  endfunction

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst_i       = v.rst;
    start_i     = v.start;
    stop_i      = v.stop;
    clear_i     = v.clear;
    lap_i       = v.lap;
    max_i       = v.max;
    count_bcd_i = v.cnt;
  endtask

  task automatic idle_inputs();
    rst_i   = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    clear_i = 1'b0;
    lap_i   = 1'b0;
    max_i   = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [15:0] C = 16'h0042;

  initial begin
    int n;
    logic found;

    // Rows: rst start stop clear lap max cnt | tick clr state disp
    // First tick pattern after start at row 0: ticks at rows 4, 8, 12.
    add_vec(0,1,0,0,0,0,C, 0,0,0,C);
    for (int i = 1; i <= 12; i++) add_vec(0,0,0,0,0,0,C, (i % 4 == 0),0,1,C);
    add_vec(0,0,1,0,0,0,C, 0,0,1,C);               // 13 stop
    add_vec(0,0,0,1,0,0,C, 0,0,2,C);               // 14 clear in PAUSE
    add_vec(0,0,0,0,0,0,C, 0,1,0,C);               // 15 clr_o pulse
    // Pause/resume: start at 16, stop at 18, start at 26 -> tick at 28.
    add_vec(0,1,0,0,0,0,C, 0,0,0,C);               // 16
    add_vec(0,0,0,0,0,0,C, 0,0,1,C);               // 17
    add_vec(0,0,1,0,0,0,C, 0,0,1,C);               // 18 stop
    add_vec(0,0,0,0,0,0,C, 0,0,2,C);               // 19
    add_vec(0,0,0,0,1,0,C, 0,0,2,C);               // 20 lap ignored
    add_vec(0,0,1,0,0,0,C, 0,0,2,C);               // 21 stop ignored
    for (int i = 22; i <= 25; i++) add_vec(0,0,0,0,0,0,C, 0,0,2,C);
    add_vec(0,1,0,0,0,0,C, 0,0,2,C);               // 26 resume
    add_vec(0,0,0,0,0,0,C, 0,0,1,C);               // 27
    add_vec(0,0,0,0,0,0,C, 1,0,1,C);               // 28 tick
    // Lap freeze and release.
    add_vec(0,0,0,0,1,0,16'h0123, 0,0,1,16'h0123); // 29 lap
    add_vec(0,0,0,0,0,0,16'h0124, 0,0,3,16'h0123); // 30
    add_vec(0,0,0,0,0,0,16'h0125, 0,0,3,16'h0123); // 31
    add_vec(0,0,0,0,0,0,16'h0125, 1,0,3,16'h0123); // 32 tick in LAP
    add_vec(0,0,0,0,1,0,16'h0126, 0,0,3,16'h0123); // 33 release
    add_vec(0,0,0,0,0,0,16'h0126, 0,0,1,16'h0126); // 34
    // Clear + stop + start together in RUN.
    add_vec(0,1,1,1,0,0,C, 0,0,1,C);               // 35
    add_vec(0,0,0,0,0,0,C, 0,1,0,C);               // 36
    for (int i = 37; i <= 40; i++) add_vec(0,0,0,0,0,0,C, 0,0,0,C);
    // Stop beats lap in LAP; start beats lap in PAUSE.
    add_vec(0,1,0,0,0,0,C, 0,0,0,C);               // 41
    add_vec(0,0,0,0,1,0,16'h0200, 0,0,1,16'h0200); // 42 lap
    add_vec(0,0,1,0,1,0,16'h0201, 0,0,3,16'h0200); // 43 stop+lap
    add_vec(0,0,0,0,0,0,16'h0202, 0,0,2,16'h0202); // 44 released
    add_vec(0,1,0,0,1,0,16'h0202, 0,0,2,16'h0202); // 45 start+lap
    add_vec(0,0,0,0,0,0,C, 0,0,1,C);               // 46
    add_vec(0,0,0,0,0,0,C, 1,0,1,C);               // 47 tick
    add_vec(0,0,0,0,0,0,C, 0,0,1,C);               // 48
    add_vec(0,0,0,0,0,0,C, 0,0,1,C);               // 49
    add_vec(0,0,0,0,0,0,C, 0,0,1,C);               // 50
    add_vec(0,0,0,0,0,1,C, 0,0,1,C);               // 51 saturate
    add_vec(0,0,0,0,0,0,C, 0,0,2,C);               // 52 PAUSE
    add_vec(0,0,0,1,0,0,C, 0,0,2,C);               // 53 clear
    add_vec(0,0,0,0,0,0,C, 0,1,0,C);               // 54
    // Reset in LAP at the end of a period.
    add_vec(0,1,0,0,0,0,C, 0,0,0,C);               // 55
    add_vec(0,0,0,0,1,0,16'h0777, 0,0,1,16'h0777); // 56 lap
    add_vec(0,0,0,0,0,0,16'h0778, 0,0,3,16'h0777); // 57
    add_vec(0,0,0,0,0,0,16'h0779, 0,0,3,16'h0777); // 58
    add_vec(1,1,0,0,0,0,16'h0779, 0,0,3,16'h0777); // 59 reset, no tick
    add_vec(0,0,0,0,0,0,16'h0780, 0,0,0,16'h0780); // 60
    add_vec(0,1,0,0,0,0,C, 0,0,0,C);               // 61
    add_vec(0,0,0,0,0,0,C, 0,0,1,C);               // 62
    add_vec(0,0,0,0,0,0,C, 0,0,1,C);               // 63
    add_vec(0,0,0,0,0,0,C, 0,0,1,C);               // 64
    add_vec(0,0,0,0,0,0,C, 1,0,1,C);               // 65 full period
    add_vec(1,0,0,1,0,0,C, 0,0,1,C);               // 66 reset masks clear
    add_vec(0,0,0,0,0,0,C, 0,0,0,C);               // 67 no clr_o

    // Reset and reset-state check.
    idle_inputs();
    count_bcd_i = 16'h0555;
    rst_i = 1'b1;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_output("reset state", 16'(state_o), 16'd0);
    check_output("reset tick", 16'(tick_o), 16'd0);
    check_output("reset clr", 16'(clr_o), 16'd0);
    check_output("reset disp", disp_bcd_o, 16'h0555);
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk_i);
      check_output($sformatf("row%0d tick", i), 16'(tick_o), 16'(vecs[i].tick));
      check_output($sformatf("row%0d clr", i), 16'(clr_o), 16'(vecs[i].clr));
      check_output($sformatf("row%0d state", i), 16'(state_o), 16'(vecs[i].st));
      check_output($sformatf("row%0d disp", i), disp_bcd_o, vecs[i].disp);
      next_cycle();
    end

    // Bounded wait for the first tick after a start from IDLE.
    idle_inputs();
    count_bcd_i = C;
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      n++;
      @(negedge clk_i);
      if (tick_o) found = 1'b1;
      else next_cycle();
    end
    check_output("first tick seen", 16'(found), 16'd1);
    check_output("first tick latency", 16'(n), 16'(DIV));
    next_cycle();
    @(negedge clk_i);
    check_output("tick width", 16'(tick_o), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
